// File: rtl/mdu_if.sv
// EX-stage multiply/divide unit bus: decoded op, forwarded operands, busy/start status
// and the architectural HI/LO view.
interface mdu_if;
  logic [3:0]  MDUOp;
  logic        MDUWr;
  logic        flush;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        start;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDUOp, MDUWr, flush, A, B,
    input  busy, start, Out, HI, LO
  );

  modport slave (
    input  MDUOp, MDUWr, flush, A, B,
    output busy, start, Out, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at start into a
// shadow register and committed to HI/LO when the busy countdown expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [3:0] MduMult  = 4'd0;
  localparam logic [3:0] MduMultu = 4'd1;
  localparam logic [3:0] MduDiv   = 4'd2;
  localparam logic [3:0] MduDivu  = 4'd3;
  localparam logic [3:0] MduMadd  = 4'd4;
  localparam logic [3:0] MduMaddu = 4'd5;
  localparam logic [3:0] MduMsub  = 4'd6;
  localparam logic [3:0] MduMsubu = 4'd7;
  localparam logic [3:0] MduMul   = 4'd8;
  localparam logic [3:0] MduMthi  = 4'd9;
  localparam logic [3:0] MduMtlo  = 4'd10;
  localparam logic [3:0] MduHi    = 4'd11;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [31:0]     hi_q, lo_q;
  logic [CntW-1:0] cnt_q;
  logic [63:0]     shadow_q;

  logic accept, is_mult, is_div;

  assign accept = bus.MDUWr & ~bus.flush & (state_q == StIdle);

  always_comb begin
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (bus.MDUOp)
      MduMult, MduMultu, MduMadd, MduMaddu, MduMsub, MduMsubu, MduMul: is_mult = 1'b1;
      MduDiv, MduDivu:                                                  is_div  = 1'b1;
      default: ;
    endcase
  end

  assign bus.start = accept & (is_mult | is_div);

  // Low 64 bits of a 64x64 product of extended operands give the exact 32x32 product.
  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc;
  assign a_sx   = {{32{bus.A[31]}}, bus.A};
  assign b_sx   = {{32{bus.B[31]}}, bus.B};
  assign a_zx   = {32'd0, bus.A};
  assign b_zx   = {32'd0, bus.B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {hi_q, lo_q};

  // One unsigned divider on magnitudes; signs are restored afterwards so that
  // 0x80000000 / -1 wraps to 0x80000000 without signed overflow.
  logic        signed_div, a_neg, b_neg, b_zero;
  logic [31:0] dividend, divisor, quo_u, rem_u, quo_s, rem_s;
  assign signed_div = (bus.MDUOp == MduDiv);
  assign a_neg      = signed_div & bus.A[31];
  assign b_neg      = signed_div & bus.B[31];
  assign b_zero     = (bus.B == 32'd0);
  assign dividend   = a_neg ? -bus.A : bus.A;
  assign divisor    = b_zero ? 32'd1 : (b_neg ? -bus.B : bus.B);
  assign quo_u      = dividend / divisor;
  assign rem_u      = dividend % divisor;
  assign quo_s      = (a_neg ^ b_neg) ? -quo_u : quo_u;
  assign rem_s      = a_neg ? -rem_u : rem_u;

  logic [63:0] result;
  always_comb begin
    result = acc;
    case (bus.MDUOp)
      MduMult:  result = prod_s;
      MduMultu: result = prod_u;
      MduMadd:  result = acc + prod_s;
      MduMaddu: result = acc + prod_u;
      MduMsub:  result = acc - prod_s;
      MduMsubu: result = acc - prod_u;
      MduMul:   result = {hi_q, prod_s[31:0]};
      MduDiv:   if (!b_zero) result = {rem_s, quo_s};
      MduDivu:  if (!b_zero) result = {rem_u, quo_u};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      cnt_q    <= '0;
      shadow_q <= 64'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            shadow_q <= result;
            cnt_q    <= is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_q  <= StBusy;
          end else if (accept && bus.MDUOp == MduMthi) begin
            hi_q <= bus.A;
          end else if (accept && bus.MDUOp == MduMtlo) begin
            lo_q <= bus.A;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            {hi_q, lo_q} <= shadow_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = (state_q == StBusy);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Out  = (bus.MDUOp == MduHi) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus random ops against a
// 64-bit arithmetic reference model of HI/LO.
module tb_mdu;

  localparam logic [3:0] MduMult  = 4'd0;
  localparam logic [3:0] MduMultu = 4'd1;
  localparam logic [3:0] MduDiv   = 4'd2;
  localparam logic [3:0] MduDivu  = 4'd3;
  localparam logic [3:0] MduMadd  = 4'd4;
  localparam logic [3:0] MduMaddu = 4'd5;
  localparam logic [3:0] MduMsub  = 4'd6;
  localparam logic [3:0] MduMsubu = 4'd7;
  localparam logic [3:0] MduMul   = 4'd8;
  localparam logic [3:0] MduMthi  = 4'd9;
  localparam logic [3:0] MduMtlo  = 4'd10;
  localparam logic [3:0] MduHi    = 4'd11;
  localparam logic [3:0] MduLo    = 4'd12;

  localparam int NMult = 5;
  localparam int NDiv  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu #(
    .MULT_CYCLES(NMult),
    .DIV_CYCLES (NDiv)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] pend;
  int          pend_n;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
    return op <= MduMul;
  endfunction

  // Reference: spec arithmetic in plain 64-bit integer math.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint      sa, sb;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {hi, lo};
    case (op)
      MduMult:  return 64'(sa * sb);
      MduMultu: return ua * ub;
      MduMadd:  return acc + 64'(sa * sb);
      MduMaddu: return acc + ua * ub;
      MduMsub:  return acc - 64'(sa * sb);
      MduMsubu: return acc - ua * ub;
      MduMul:   return {hi, 32'(sa * sb)};
      MduDiv:   return (b == 0) ? acc : {32'(sa % sb), 32'(sa / sb)};
      MduDivu:  return (b == 0) ? acc : {32'(ua % ub), 32'(ua / ub)};
      default:  return acc;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    bus.MDUOp = MduHi;
    #1 check_eq({tag, "_out_hi"}, bus.Out, m_hi);
    bus.MDUOp = MduLo;
    #1 check_eq({tag, "_out_lo"}, bus.Out, m_lo);
    check_eq({tag, "_hi"}, bus.HI, m_hi);
    check_eq({tag, "_lo"}, bus.LO, m_lo);
  endtask

  // Issue one write from idle; updates the model and leaves just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    @(negedge clk);
    bus.MDUOp = op;
    bus.MDUWr = 1'b1;
    bus.flush = fl;
    bus.A     = a;
    bus.B     = b;
    #1 check_eq("start", bus.start, !fl && is_multi(op));
    pend_n = 0;
    if (!fl) begin
      if (op == MduMthi) m_hi = a;
      else if (op == MduMtlo) m_lo = a;
      else if (is_multi(op)) begin
        pend   = ref_result(op, a, b, m_hi, m_lo);
        pend_n = (op == MduDiv || op == MduDivu) ? NDiv : NMult;
      end
    end
    @(posedge clk);
    #1;
    bus.MDUWr = 1'b0;
    bus.flush = 1'b0;
  endtask

  // Count remaining busy cycles (bounded), checking HI/LO hold, then check the commit.
  task automatic finish_op(input int remaining, input string tag);
    int cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      check_eq({tag, "_hold_hi"}, bus.HI, m_hi);
      check_eq({tag, "_hold_lo"}, bus.LO, m_lo);
      cnt++;
    end
    check_eq({tag, "_busy_cycles"}, cnt, remaining);
    if (pend_n != 0) {m_hi, m_lo} = pend;
    pend_n = 0;
    check_regs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        fl;
    int          sel;

    reset     = 1'b1;
    bus.MDUOp = MduLo;
    bus.MDUWr = 1'b0;
    bus.flush = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    pend_n    = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", bus.busy, 1'b0);
    check_regs("reset");

    issue(MduMult, 32'hFFFF_FFFE, 32'd3, 1'b0);
    finish_op(pend_n, "mult");
    check_eq("mult_hi_const", bus.HI, 32'hFFFF_FFFF);
    check_eq("mult_lo_const", bus.LO, 32'hFFFF_FFFA);

    issue(MduDiv, -32'sd7, 32'd2, 1'b0);
    finish_op(pend_n, "div");
    check_eq("div_lo_const", bus.LO, 32'hFFFF_FFFD);
    check_eq("div_hi_const", bus.HI, 32'hFFFF_FFFF);

    issue(MduMtlo, 32'h55, 32'd0, 1'b0);
    finish_op(pend_n, "mtlo");
    issue(MduMthi, 32'hAA, 32'd0, 1'b0);
    finish_op(pend_n, "mthi");
    issue(MduDivu, 32'd7, 32'd0, 1'b0);
    finish_op(pend_n, "divu0");
    check_eq("divu0_hi_const", bus.HI, 32'hAA);
    check_eq("divu0_lo_const", bus.LO, 32'h55);

    issue(MduMthi, 32'd0, 32'd0, 1'b0);
    finish_op(pend_n, "mthi0");
    issue(MduMtlo, 32'hFFFF_FFFF, 32'd0, 1'b0);
    finish_op(pend_n, "mtlo1");
    issue(MduMaddu, 32'd1, 32'd1, 1'b0);
    finish_op(pend_n, "maddu");
    check_eq("maddu_const", {bus.HI, bus.LO}, 64'h1_0000_0000);

    issue(MduDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    finish_op(pend_n, "divovf");
    check_eq("divovf_const", {bus.HI, bus.LO}, {32'd0, 32'h8000_0000});

    issue(MduMult, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    finish_op(pend_n, "flush");

    // mtlo arriving while busy must be ignored.
    issue(MduMult, 32'd1000, 32'd1000, 1'b0);
    @(negedge clk);
    check_eq("ign_busy", bus.busy, 1'b1);
    bus.MDUOp = MduMtlo;
    bus.MDUWr = 1'b1;
    bus.A     = 32'h1234;
    #1 check_eq("ign_start", bus.start, 1'b0);
    @(posedge clk);
    #1 bus.MDUWr = 1'b0;
    finish_op(pend_n - 1, "ignored");

    issue(MduMultu, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rstmid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    pend_n = 0;
    @(negedge clk);
    check_eq("rstmid_busy_clr", bus.busy, 1'b0);
    check_regs("rstmid");

    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 10));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) b = 32'($urandom_range(1, 9));
      fl = ($urandom_range(0, 7) == 0);
      issue(op, a, b, fl);
      finish_op(pend_n, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the EX stage. It consumes `MDUOp`/`MDUWr` decoded by the controller together with forwarded rs/rt operands. It owns the architectural HI/LO registers and reports `busy` so the hazard unit can stall any `MDUDp` instruction in E while an operation is in flight. The `mfhi`/`mflo` result leaves through `Out` into the E/M pipeline register.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu/mul/madd/maddu/msub/msubu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.
- `clk` input 1: clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `MDUOp` input `MDUOp_len`: operation, using the `MDU_*` codes from def.v.
- `MDUWr` input 1: the E-stage instruction writes MDU state (start or mt*).
- `flush` input 1: the E-stage instruction is cancelled by an exception or interrupt. This suppresses the MDUWr of the same cycle.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `busy` output 1: an operation is in flight.
- `start` output 1: combinational. High when `MDUWr & ~flush & ~busy` and `MDUOp` is a multi-cycle op.
- `Out` output 32: combinational. HI when `MDUOp`=`MDU_hi`, otherwise LO.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- **Reset:** HI=0, LO=0, busy=0, cycle counter=0, shadow result=0.
- **Idle:** busy=0. HI/LO are held.
- **Accepted write:** a write is accepted when `MDUWr & ~flush & ~busy`.
- **mthi:** HI<=A at the next edge. LO is unchanged. No busy.
- **mtlo:** LO<=A at the next edge. HI is unchanged. No busy.
- **Multi-cycle start:** `start`=1. At the edge:
  - the 64-bit result is computed from A, B and the current HI/LO, and stored in a shadow register;
  - the counter is loaded with N (`MULT_CYCLES` or `DIV_CYCLES`);
  - busy<=1.
- **Busy:** the counter decrements each edge. On the edge where it goes 1->0:
  - the shadow result is written to HI/LO;
  - busy<=0 on that same edge.
- **Arithmetic rules:**
  - mult: {HI,LO}=signed A*B (64-bit).
  - multu: {HI,LO}=unsigned A*B (64-bit).
  - madd: {HI,LO}+=signed A*B, modulo 2^64.
  - maddu: {HI,LO}+=unsigned A*B, modulo 2^64.
  - msub: {HI,LO}-=signed A*B, modulo 2^64.
  - msubu: {HI,LO}-=unsigned A*B, modulo 2^64.
  - mul: LO=low 32 bits of signed A*B. HI is unchanged.
  - div: LO=signed quotient, truncated toward zero. HI=remainder, with the sign of the dividend.
  - divu: LO=unsigned quotient, HI=unsigned remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): the op still runs `DIV_CYCLES` with busy. HI/LO are left unchanged at completion.
- **Boundary conditions:**
  - `MDUWr` while busy=1: ignored, no state change. The hazard unit guarantees this does not happen; the bench checks that it is benign.
  - `flush` with `MDUWr`: no start and no mt write. `flush` does not abort an in-flight operation, which belongs to an already-committed instruction.
  - `MDUWr`=0 (mfhi/mflo or any non-MDU op): no state change.
  - `reset` mid-operation: busy=0, the result is discarded, HI=LO=0 at that edge.

## Timing
- **Start latency:** MDUWr sampled at edge T0 gives busy=1 from T0 until edge T0+N. HI/LO take the new value at T0+N, and busy falls at T0+N.
- **Back-to-back starts:** the next multi-cycle start can be accepted in the cycle after busy falls.
- **mt* latency:** HI/LO are visible on `HI`/`LO`/`Out` one edge after acceptance.
- **Out:** purely combinational from HI/LO. There is no internal bypass of a pending result; a read during busy is stalled upstream.
- **start:** never asserted while busy=1.

## Test plan
- **Reset:** assert reset for 2 cycles -> HI=LO=0, busy=0, Out=0.
- **mult:** A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles. HI=0xFFFFFFFF, LO=0xFFFFFFFA on the falling edge of busy. HI/LO are unchanged during busy.
- **div:** A=-7, B=2 -> 10 busy cycles. LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **divu:** A=7, B=0 after mtlo 0x55 and mthi 0xAA -> 10 busy cycles, then HI=0xAA, LO=0x55.
- **madd:** preload HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0.
- **flush:** mult with flush=1 -> no busy, HI/LO unchanged.
- **Ignored write:** mtlo issued while busy -> ignored.
- **Reset mid-op:** reset at busy cycle 3 -> busy=0, HI=LO=0 next cycle.
